// File: rtl/instr_fetcher_pkg.sv
// Shared encodings for the instruction fetcher: control-unit states, fetch states, word width.
package instr_fetcher_pkg;

  localparam int INSTR_WIDTH = 16;

  typedef enum logic [3:0] {
    CU_RESET   = 4'd0,
    CU_FETCH   = 4'd1,
    CU_DECODE  = 4'd2,
    CU_REQUEST = 4'd3,
    CU_WAIT    = 4'd4,
    CU_EXECUTE = 4'd5,
    CU_UPDATE  = 4'd6,
    CU_DONE    = 4'd7
  } cu_state_e;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_FETCHING = 2'd1,
    FS_FETCHED  = 2'd2,
    FS_ERROR    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetcher.sv
// Instruction fetcher: one program-memory read per control-unit FETCH phase, result held for decode.
// Optional FETCH_TIMEOUT_EN adds a wait counter that abandons a stalled read into ERROR.
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter int PC_ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               cu_state,
  input  logic [PC_ADDR_WIDTH-1:0] next_pc,
  output logic                     mem_read_valid,
  output logic [PC_ADDR_WIDTH-2:0] mem_read_addr,
  input  logic                     mem_read_ready,
  input  logic [INSTR_WIDTH-1:0]   mem_read_data,
  output logic [INSTR_WIDTH-1:0]   instruction,
  output logic [1:0]               fetch_state,
  output logic                     fetch_done,
  output logic                     misaligned
);

  fetch_state_e state, state_nxt;
  logic         start_fetch;
  logic         complete_fetch;
  logic         timeout_hit;
  logic         in_fetch;

  assign in_fetch = (cu_state == CU_FETCH);

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  // Counts FETCHING cycles without ready; zeroed whenever a new request is launched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (start_fetch) begin
      wait_cnt <= '0;
    end else if (state == FS_FETCHING && !mem_read_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign timeout_hit = (state == FS_FETCHING) && !mem_read_ready && (wait_cnt == WAIT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    start_fetch    = 1'b0;
    complete_fetch = 1'b0;
    unique case (state)
      FS_IDLE: begin
        if (in_fetch) begin
          start_fetch = 1'b1;
          state_nxt   = FS_FETCHING;
        end
      end
      FS_FETCHING: begin
        // A request already on the bus always completes, even if the CU has moved on.
        if (mem_read_ready) begin
          complete_fetch = 1'b1;
          state_nxt      = FS_FETCHED;
        end else if (timeout_hit) begin
          state_nxt = FS_ERROR;
        end
      end
      FS_FETCHED: begin
        if (!in_fetch) state_nxt = FS_IDLE;
      end
      FS_ERROR: state_nxt = FS_ERROR;
      default:  state_nxt = FS_IDLE;
    endcase
  end

  // Stage p0: request launch, completion capture and sticky alignment flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= FS_IDLE;
      mem_read_valid <= 1'b0;
      mem_read_addr  <= '0;
      instruction    <= '0;
      misaligned     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_fetch) begin
        mem_read_addr  <= next_pc[PC_ADDR_WIDTH-1:1];
        mem_read_valid <= 1'b1;
        misaligned     <= misaligned | next_pc[0];
      end
      if (complete_fetch) begin
        instruction    <= mem_read_data;
        mem_read_valid <= 1'b0;
      end
      if (timeout_hit) mem_read_valid <= 1'b0;
    end
  end

  assign fetch_state = state;
  assign fetch_done  = (state == FS_FETCHED);

endmodule

// File: tb/tb_instr_fetcher.sv
// Self-checking bench for instr_fetcher: directed scenarios plus randomized fetches against a transaction-level model.
module tb_instr_fetcher;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO  = 4;
  localparam int MAXW = 2;
`else
  localparam int TMO  = 64;
  localparam int MAXW = 6;
`endif
  localparam int WS_WAIT = (MAXW < 5) ? MAXW : 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cu_state;
  logic [7:0]  next_pc;
  logic        mem_read_valid;
  logic [6:0]  mem_read_addr;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [15:0] instruction;
  logic [1:0]  fetch_state;
  logic        fetch_done;
  logic        misaligned;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Transaction-level model: last completed instruction and sticky misalignment.
  logic [15:0] m_instr;
  logic        m_mis;

  instr_fetcher #(
    .PC_ADDR_WIDTH (8),
    .INSTR_WIDTH   (16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cu_state      (cu_state),
    .next_pc       (next_pc),
    .mem_read_valid(mem_read_valid),
    .mem_read_addr (mem_read_addr),
    .mem_read_ready(mem_read_ready),
    .mem_read_data (mem_read_data),
    .instruction   (instruction),
    .fetch_state   (fetch_state),
    .fetch_done    (fetch_done),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: issue one fetch and report what the DUT showed. lat = cycles from FETCH seen to fetch_done.
  task automatic run_fetch(input logic [7:0] pc, input logic [15:0] d, input int w, input bit wander,
                           output logic [6:0] addr0, output bit held, output int lat,
                           output logic [15:0] instr_o);
    cu_state = 4'd1; next_pc = pc; mem_read_ready = 1'b0;
    tick(); lat = 1;
    addr0 = mem_read_addr;
    held  = mem_read_valid && (fetch_state == 2'd1);
    for (int i = 0; i < w; i++) begin
      if (wander) begin
        next_pc  = 8'($urandom);
        cu_state = ($urandom_range(0, 1) == 1) ? 4'd1 : 4'd5;
      end
      tick(); lat++;
      held = held && mem_read_valid && (mem_read_addr == addr0) && !fetch_done;
    end
    mem_read_ready = 1'b1; mem_read_data = d;
    tick(); lat++;
    mem_read_ready = 1'b0; mem_read_data = 16'($urandom);
    for (int k = 0; k < 8 && !fetch_done; k++) begin
      tick(); lat++;
    end
    if (!fetch_done) lat = -1;
    instr_o = instruction;
  endtask

  task automatic leave_fetch();
    cu_state = 4'd5;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; cu_state = 4'd0; next_pc = 8'h00; mem_read_ready = 1'b0; mem_read_data = 16'h0;
    tick(); tick();
    cmp_cnt++;
    if ({mem_read_valid, mem_read_addr, instruction, fetch_state, fetch_done, misaligned} !== 28'h0) begin
      err_cnt++;
      $display("FAIL reset_init: valid=%b addr=%h instr=%h state=%0d done=%b mis=%b, required all zero",
               mem_read_valid, mem_read_addr, instruction, fetch_state, fetch_done, misaligned);
    end
    reset = 1'b1;
    m_instr = 16'h0; m_mis = 1'b0;
    tick();
    cmp_cnt++;
    if (fetch_state !== 2'd0) begin
      err_cnt++; $display("FAIL idle_after_reset: state=%0d required 0", fetch_state);
    end
  endtask

  task automatic test_zero_wait();
    logic [6:0] a; bit h; int lat; logic [15:0] ins;
    run_fetch(8'h10, 16'h5A3C, 0, 1'b0, a, h, lat, ins);
    m_instr = 16'h5A3C;
    cmp_cnt++;
    if (a !== 7'h08 || !h) begin
      err_cnt++; $display("FAIL zero_wait_req: addr=%h held=%0d required addr=08 held=1", a, h);
    end
    cmp_cnt++;
    if (lat !== 2 || ins !== 16'h5A3C || mem_read_valid !== 1'b0) begin
      err_cnt++; $display("FAIL zero_wait_done: lat=%0d instr=%h valid=%b required lat=2 instr=5a3c valid=0",
                          lat, ins, mem_read_valid);
    end
    leave_fetch();
    cmp_cnt++;
    if (fetch_state !== 2'd0 || fetch_done !== 1'b0 || instruction !== m_instr) begin
      err_cnt++; $display("FAIL zero_wait_leave: state=%0d done=%b instr=%h required state=0 done=0 instr=%h",
                          fetch_state, fetch_done, instruction, m_instr);
    end
  endtask

  task automatic test_wait_states();
    logic [6:0] a; bit h; int lat; logic [15:0] ins;
    cu_state = 4'd1; next_pc = 8'h10; mem_read_ready = 1'b0;
    tick();
    a = mem_read_addr; h = mem_read_valid; lat = 1;
    next_pc = 8'h20;
    for (int i = 0; i < WS_WAIT; i++) begin
      tick(); lat++;
      h = h && mem_read_valid && (mem_read_addr == 7'h08) && !fetch_done;
    end
    mem_read_ready = 1'b1; mem_read_data = 16'hC0DE;
    tick(); lat++;
    mem_read_ready = 1'b0;
    m_instr = 16'hC0DE;
    cmp_cnt++;
    if (a !== 7'h08 || !h) begin
      err_cnt++; $display("FAIL wait_addr_hold: addr=%h held=%0d required addr=08 held=1", a, h);
    end
    cmp_cnt++;
    if (fetch_done !== 1'b1 || instruction !== 16'hC0DE || lat !== WS_WAIT + 2) begin
      err_cnt++; $display("FAIL wait_done: done=%b instr=%h lat=%0d required done=1 instr=c0de lat=%0d",
                          fetch_done, instruction, lat, WS_WAIT + 2);
    end
    leave_fetch();
  endtask

  task automatic test_hold_rearm();
    logic [6:0] a; bit h; int lat; logic [15:0] ins; int reqs;
    run_fetch(8'h30, 16'h1234, 1, 1'b0, a, h, lat, ins);
    m_instr = 16'h1234;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_read_valid) reqs++;
    end
    cmp_cnt++;
    if (reqs !== 0 || fetch_done !== 1'b1 || instruction !== m_instr) begin
      err_cnt++; $display("FAIL hold_no_refetch: extra_reqs=%0d done=%b instr=%h required 0/1/%h",
                          reqs, fetch_done, instruction, m_instr);
    end
    cu_state = 4'd2; tick();
    cu_state = 4'd1; next_pc = 8'h12; tick();
    cmp_cnt++;
    if (mem_read_valid !== 1'b1 || mem_read_addr !== 7'h09) begin
      err_cnt++; $display("FAIL rearm_req: valid=%b addr=%h required valid=1 addr=09", mem_read_valid, mem_read_addr);
    end
    mem_read_ready = 1'b1; mem_read_data = 16'h4321; tick(); mem_read_ready = 1'b0;
    m_instr = 16'h4321;
    leave_fetch();
  endtask

  task automatic test_misaligned();
    logic [6:0] a; bit h; int lat; logic [15:0] ins;
    run_fetch(8'h13, 16'hAA55, 0, 1'b0, a, h, lat, ins);
    m_instr = 16'hAA55; m_mis = 1'b1;
    cmp_cnt++;
    if (a !== 7'h09 || misaligned !== 1'b1 || ins !== 16'hAA55) begin
      err_cnt++; $display("FAIL misaligned_set: addr=%h mis=%b instr=%h required 09/1/aa55", a, misaligned, ins);
    end
    leave_fetch();
    run_fetch(8'h20, 16'h0F0F, 1, 1'b0, a, h, lat, ins);
    m_instr = 16'h0F0F;
    cmp_cnt++;
    if (misaligned !== 1'b1 || a !== 7'h10) begin
      err_cnt++; $display("FAIL misaligned_sticky: mis=%b addr=%h required 1/10", misaligned, a);
    end
    leave_fetch();
  endtask

  task automatic test_random();
    logic [6:0] a; bit h; int lat; logic [15:0] ins;
    logic [7:0] pc; logic [15:0] d; int w; int bad;
    bad = 0;
    for (int n = 0; n < 24; n++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        cu_state = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'd7;
        mem_read_ready = 1'($urandom); mem_read_data = 16'($urandom);
        tick();
      end
      pc = 8'($urandom); d = 16'($urandom); w = $urandom_range(0, MAXW);
      run_fetch(pc, d, w, 1'b1, a, h, lat, ins);
      m_instr = d; m_mis = m_mis | pc[0];
      cmp_cnt++;
      if (a !== pc[7:1] || !h || lat !== w + 2 || ins !== m_instr || misaligned !== m_mis) begin
        err_cnt++; bad++;
        if (bad < 6)
          $display("FAIL rand_fetch[%0d]: addr=%h held=%0d lat=%0d instr=%h mis=%b required %h/1/%0d/%h/%b",
                   n, a, h, lat, ins, misaligned, pc[7:1], w + 2, m_instr, m_mis);
      end
      leave_fetch();
      mem_read_ready = 1'b1; mem_read_data = 16'($urandom);
      tick();
      mem_read_ready = 1'b0;
      cmp_cnt++;
      if (fetch_state !== 2'd0 || instruction !== m_instr) begin
        err_cnt++; $display("FAIL rand_idle_ignore[%0d]: state=%0d instr=%h required 0/%h", n, fetch_state, instruction, m_instr);
      end
    end
  endtask

  task automatic test_reset_midfetch();
    cu_state = 4'd1; next_pc = 8'h11; mem_read_ready = 1'b0;
    tick();
    reset = 1'b0; tick(); tick();
    cmp_cnt++;
    if ({mem_read_valid, mem_read_addr, instruction, fetch_state, fetch_done, misaligned} !== 28'h0) begin
      err_cnt++;
      $display("FAIL reset_mid: valid=%b addr=%h instr=%h state=%0d done=%b mis=%b, required all zero",
               mem_read_valid, mem_read_addr, instruction, fetch_state, fetch_done, misaligned);
    end
    reset = 1'b1; cu_state = 4'd2; mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    tick();
    mem_read_ready = 1'b0;
    m_instr = 16'h0; m_mis = 1'b0;
    cmp_cnt++;
    if (instruction !== 16'h0 || fetch_state !== 2'd0 || mem_read_valid !== 1'b0) begin
      err_cnt++; $display("FAIL reset_late_ready: instr=%h state=%0d valid=%b required 0000/0/0",
                          instruction, fetch_state, mem_read_valid);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    cu_state = 4'd1; next_pc = 8'h40; mem_read_ready = 1'b0;
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    cmp_cnt++;
    if (fetch_state !== 2'd1 || mem_read_valid !== 1'b1) begin
      err_cnt++; $display("FAIL timeout_early: state=%0d valid=%b required 1/1", fetch_state, mem_read_valid);
    end
    tick();
    cmp_cnt++;
    if (fetch_state !== 2'd3 || mem_read_valid !== 1'b0 || fetch_done !== 1'b0 || instruction !== m_instr) begin
      err_cnt++; $display("FAIL timeout_error: state=%0d valid=%b done=%b instr=%h required 3/0/0/%h",
                          fetch_state, mem_read_valid, fetch_done, instruction, m_instr);
    end
    cu_state = 4'd5; tick(); tick();
    cmp_cnt++;
    if (fetch_state !== 2'd3) begin
      err_cnt++; $display("FAIL error_sticky: state=%0d required 3", fetch_state);
    end
    reset = 1'b0; tick(); reset = 1'b1; tick();
    cu_state = 4'd1; next_pc = 8'h40;
    tick();
    for (int i = 0; i < TMO - 1; i++) tick();
    mem_read_ready = 1'b1; mem_read_data = 16'h7E57;
    tick();
    mem_read_ready = 1'b0;
    cmp_cnt++;
    if (fetch_state !== 2'd2 || instruction !== 16'h7E57) begin
      err_cnt++; $display("FAIL timeout_ready_wins: state=%0d instr=%h required 2/7e57", fetch_state, instruction);
    end
    leave_fetch();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_hold_rearm();
    test_random();
    test_misaligned();
    test_reset_midfetch();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
